// File: rtl/fetch_queue_if.sv
// Bundle of the fetch front end's memory read port, writeback control
// and decode handshake. The master side belongs to fetch_queue.
interface fetch_queue_if;
   logic [14:0] mem_raddr;
   logic [15:0] mem_rdata;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt;
   logic        dec_valid;
   logic [15:0] dec_inst;
   logic [15:0] dec_pc;
   logic        dec_ready;

   modport master (
      output mem_raddr, dec_valid, dec_inst, dec_pc,
      input  mem_rdata, redirect, redirect_pc, halt, dec_ready
   );

   modport slave (
      input  mem_raddr, dec_valid, dec_inst, dec_pc,
      output mem_rdata, redirect, redirect_pc, halt, dec_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch front end: issues one read per cycle,
// tracks reads across a fixed memory latency and buffers returned words
// in a small FIFO popped by decode. Redirect flushes everything.
module fetch_queue #(
   parameter int DEPTH   = 4,
   parameter int MEM_LAT = 2
) (
   input logic          clk,
   input logic          rst_n,
   fetch_queue_if.master fq
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   // Wide enough for buffered words plus every in-flight read.
   localparam int SW = $clog2(DEPTH + MEM_LAT + 1);

   typedef struct packed {
      logic [15:0] inst;
      logic [15:0] pc;
   } entry_t;

   logic [15:0]        fetch_pc_q, fetch_pc_d;
   logic [MEM_LAT-1:0] infl_valid_q, infl_valid_d;
   logic [15:0]        infl_pc_q [MEM_LAT];
   logic [15:0]        infl_pc_d [MEM_LAT];
   entry_t             fifo_q [DEPTH];
   entry_t             fifo_d [DEPTH];
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]      count_q, count_d;

   logic [SW-1:0]      credit_used;
   logic               issue;
   logic               push;
   logic               pop;

   assign fq.mem_raddr = fetch_pc_q[15:1];
   assign fq.dec_valid = (count_q != '0);
   assign fq.dec_inst  = fifo_q[rd_ptr_q].inst;
   assign fq.dec_pc    = fifo_q[rd_ptr_q].pc;

   assign push = infl_valid_q[MEM_LAT-1];
   assign pop  = fq.dec_valid && fq.dec_ready;

   // Credits: a read may issue only if its word is sure to find a FIFO slot.
   always_comb begin
      credit_used = SW'(count_q);
      for (int i = 0; i < MEM_LAT; i++) begin
         credit_used = credit_used + SW'(infl_valid_q[i]);
      end
      issue = !fq.redirect && !fq.halt && (credit_used < SW'(DEPTH));
   end

   // Next state: redirect flushes and restarts; otherwise issue, shift, push, pop.
   always_comb begin
      // NOTE: every next-state variable is defaulted first so no path leaves
      // a variable unassigned and a latch can never be inferred.
      fetch_pc_d   = fetch_pc_q;
      infl_valid_d = infl_valid_q;
      infl_pc_d    = infl_pc_q;
      fifo_d       = fifo_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;

      if (fq.redirect) begin
         fetch_pc_d   = fq.redirect_pc & 16'hFFFE;
         infl_valid_d = '0;
         rd_ptr_d     = '0;
         wr_ptr_d     = '0;
         count_d      = '0;
      end else begin
         for (int i = 1; i < MEM_LAT; i++) begin
            infl_valid_d[i] = infl_valid_q[i-1];
            infl_pc_d[i]    = infl_pc_q[i-1];
         end
         infl_valid_d[0] = issue;
         infl_pc_d[0]    = fetch_pc_q;
         if (issue) begin
            fetch_pc_d = fetch_pc_q + 16'd2;
         end

         if (push) begin
            fifo_d[wr_ptr_q] = '{inst: fq.mem_rdata, pc: infl_pc_q[MEM_LAT-1]};
            wr_ptr_d         = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q   <= '0;
         infl_valid_q <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         for (int i = 0; i < MEM_LAT; i++) begin
            infl_pc_q[i] <= '0;
         end
         // NOTE: the small buffer is reset as well so dec_inst/dec_pc read
         // zero out of reset instead of uninitialised storage.
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every register samples
         // pre-edge values regardless of statement order.
         fetch_pc_q   <= fetch_pc_d;
         infl_valid_q <= infl_valid_d;
         infl_pc_q    <= infl_pc_d;
         fifo_q       <= fifo_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based model.
module tb_fetch_queue;

   localparam int DEPTH   = 4;
   localparam int MEM_LAT = 2;

   logic clk;
   logic rst_n;
   fetch_queue_if fq ();

   fetch_queue #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fq    (fq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: word at byte address A is 0x1000 | A.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return 16'h1000 | a;
   endfunction

   // Instruction memory with fixed read latency.
   logic [14:0] a_pipe [MEM_LAT];
   always @(posedge clk) begin
      a_pipe[0] <= fq.mem_raddr;
      for (int i = 1; i < MEM_LAT; i++) a_pipe[i] <= a_pipe[i-1];
   end
   assign fq.mem_rdata = mem_word({a_pipe[MEM_LAT-1], 1'b0});

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [15:0] pc;
      logic [15:0] inst;
   } word_t;

   logic [15:0] m_pc;
   bit          m_flight_v  [MEM_LAT];
   logic [15:0] m_flight_pc [MEM_LAT];
   word_t       m_fifo [$];

   task automatic model_reset();
      m_pc = 16'h0000;
      for (int i = 0; i < MEM_LAT; i++) begin
         m_flight_v[i]  = 1'b0;
         m_flight_pc[i] = 16'h0000;
      end
      m_fifo.delete();
   endtask

   // Advance the model across one rising edge using the current inputs.
   task automatic model_edge();
      int n_flight;
      bit do_issue;
      if (fq.redirect) begin
         m_pc = fq.redirect_pc & 16'hFFFE;
         for (int i = 0; i < MEM_LAT; i++) m_flight_v[i] = 1'b0;
         m_fifo.delete();
      end else begin
         n_flight = 0;
         for (int i = 0; i < MEM_LAT; i++) n_flight += int'(m_flight_v[i]);
         do_issue = !fq.halt && (m_fifo.size() + n_flight < DEPTH);
         if (m_fifo.size() > 0 && fq.dec_ready) void'(m_fifo.pop_front());
         if (m_flight_v[MEM_LAT-1])
            m_fifo.push_back('{pc: m_flight_pc[MEM_LAT-1], inst: mem_word(m_flight_pc[MEM_LAT-1])});
         for (int i = MEM_LAT - 1; i > 0; i--) begin
            m_flight_v[i]  = m_flight_v[i-1];
            m_flight_pc[i] = m_flight_pc[i-1];
         end
         m_flight_v[0]  = do_issue;
         m_flight_pc[0] = m_pc;
         if (do_issue) m_pc = m_pc + 16'd2;
      end
   endtask

   task automatic compare_model();
      check("model_valid", 32'(fq.dec_valid), 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) begin
         check("model_pc",   32'(fq.dec_pc),   32'(m_fifo[0].pc));
         check("model_inst", 32'(fq.dec_inst), 32'(m_fifo[0].inst));
      end
      check("model_raddr", 32'(fq.mem_raddr), 32'(m_pc[15:1]));
   endtask

   // Apply inputs for one cycle, cross the edge, sample 1 time unit later.
   task automatic step(input logic r, input logic [15:0] rpc, input logic hlt, input logic rdy);
      fq.redirect    = r;
      fq.redirect_pc = rpc;
      fq.halt        = hlt;
      fq.dec_ready   = rdy;
      model_edge();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      fq.redirect    = 1'b0;
      fq.redirect_pc = 16'h0000;
      fq.halt        = 1'b0;
      fq.dec_ready   = 1'b0;
      model_reset();
      #12;
      check("rst_valid", 32'(fq.dec_valid), 32'd0);
      check("rst_inst",  32'(fq.dec_inst),  32'd0);
      check("rst_pc",    32'(fq.dec_pc),    32'd0);
      check("rst_raddr", 32'(fq.mem_raddr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        redir;
      logic [15:0] rpc;
      logic        rdy;
      logic        hlt;
      logic        exp_valid;
      logic [15:0] exp_pc;
   } vec_t;

   vec_t vecs [12];

   initial begin
      logic [15:0] exp_pc;
      bit          seen;

      vecs[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
      vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0002};
      vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0004};
      vecs[5]  = '{1'b1, 16'hFFFD, 1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hFFFC};
      vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hFFFE};
      vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
      vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0002};

      // Reset, stream from 0 and a wrapping redirect.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].redir, vecs[i].rpc, vecs[i].hlt, vecs[i].rdy);
         check($sformatf("vec%0d_valid", i), 32'(fq.dec_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) begin
            check($sformatf("vec%0d_pc", i),   32'(fq.dec_pc),   32'(vecs[i].exp_pc));
            check($sformatf("vec%0d_inst", i), 32'(fq.dec_inst), 32'(mem_word(vecs[i].exp_pc)));
         end
      end

      // Backpressure: decode stalls from the start, then releases.
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
      check("bp_count", 32'(dut.count_q), 32'd4);
      check("bp_raddr", 32'(fq.mem_raddr), 32'd4);
      check("bp_head",  32'(fq.dec_pc), 32'd0);
      exp_pc = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         if (fq.dec_valid) begin
            check("bp_seq", 32'(fq.dec_pc), 32'(exp_pc));
            exp_pc = exp_pc + 16'd2;
         end
         step(1'b0, 16'h0, 1'b0, 1'b1);
      end
      check("bp_no_gap", 32'(exp_pc), 32'd32);

      // Redirect with full FIFO and reads in flight.
      for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
      step(1'b1, 16'h0041, 1'b0, 1'b1);
      check("redir_flush", 32'(fq.dec_valid), 32'd0);
      step(1'b0, 16'h0, 1'b0, 1'b1);
      step(1'b0, 16'h0, 1'b0, 1'b1);
      check("redir_wait", 32'(fq.dec_valid), 32'd0);
      step(1'b0, 16'h0, 1'b0, 1'b1);
      check("redir_valid", 32'(fq.dec_valid), 32'd1);
      check("redir_pc0",   32'(fq.dec_pc), 32'h0040);
      step(1'b0, 16'h0, 1'b0, 1'b1);
      check("redir_pc1",   32'(fq.dec_pc), 32'h0042);

      // Halt while streaming: in-flight words drain, fetch PC freezes.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 16'h0, 1'b1, 1'b1);
         check("halt_raddr", 32'(fq.mem_raddr), 32'd5);
      end
      check("halt_drained", 32'(fq.dec_valid), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step(1'b0, 16'h0, 1'b0, 1'b1);
         if (fq.dec_valid) begin
            seen = 1'b1;
            check("halt_resume_pc", 32'(fq.dec_pc), 32'd10);
         end
      end
      check("halt_resume_seen", 32'(seen), 32'd1);

      // Reset between edges with a non-empty FIFO.
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check("mrst_valid", 32'(fq.dec_valid), 32'd0);
      check("mrst_raddr", 32'(fq.mem_raddr), 32'd0);
      check("mrst_pc",    32'(fq.dec_pc),    32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b1);
      check("mrst_restart_valid", 32'(fq.dec_valid), 32'd1);
      check("mrst_restart_pc",    32'(fq.dec_pc),    32'd0);

      // Randomized traffic against the model.
      do_reset();
      begin
         logic hlt_state;
         logic [15:0] rpc;
         hlt_state = 1'b0;
         for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) hlt_state = ~hlt_state;
            rpc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
            step(($urandom_range(0, 19) == 0), rpc, hlt_state,
                 ($urandom_range(0, 3) != 0));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
